// File: rtl/image_window_renderer.sv
// Draws a memory-backed image window (with optional border ring) into a raster stream.
// Latency MEM_LATENCY+2 cycles, one pixel per clock, no backpressure (the raster never stalls).
module image_window_renderer #(
  parameter int IMG_W       = 256,
  parameter int IMG_H       = 256,
  parameter int LEFT        = 0,
  parameter int TOP         = 0,
  parameter int SCALE_SHIFT = 0,
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 16,
  parameter int BORDER      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [1:0]        mode,
  input  logic [7:0]        threshold,
  input  logic [23:0]       border_rgb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        ReadData,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              frame_done
);

  localparam int X_END = LEFT + (IMG_W << SCALE_SHIFT);
  localparam int Y_END = TOP + (IMG_H << SCALE_SHIFT);
  localparam int BX0   = LEFT - BORDER;
  localparam int BX1   = X_END + BORDER;
  localparam int BY0   = TOP - BORDER;
  localparam int BY1   = Y_END + BORDER;
  localparam int W_LOG = $clog2(IMG_W);
  localparam int DEPTH = MEM_LATENCY + 1;

  // Per-pixel control that travels alongside the memory read.
  typedef struct packed {
    logic win;
    logic brd;
    logic last;
    logic hs;
    logic vs;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{win: 1'b0, brd: 1'b0, last: 1'b0, hs: 1'b1, vs: 1'b1};

  ctl_t              ctl_q [DEPTH];
  ctl_t              ctl_d [DEPTH];
  ctl_t              ctl_out;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [1:0]        mode_sh_q, mode_sh_d;
  logic [7:0]        thr_sh_q, thr_sh_d;
  logic [23:0]       brd_rgb_q, brd_rgb_d;
  logic [23:0]       rgb_q, rgb_d;
  logic [23:0]       pix_rgb;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              frame_done_q, frame_done_d;
  logic              in_win, in_ring, at_origin;
  int                xi, yi, src_x, src_y, addr_full;

  always_comb begin
    xi        = int'(x);
    yi        = int'(y);
    in_win    = video_on && (xi >= LEFT) && (xi < X_END) && (yi >= TOP) && (yi < Y_END);
    in_ring   = (BORDER > 0) && video_on && !in_win &&
                (xi >= BX0) && (xi < BX1) && (yi >= BY0) && (yi < BY1);
    src_x     = (xi - LEFT) >>> SCALE_SHIFT;
    src_y     = (yi - TOP) >>> SCALE_SHIFT;
    addr_full = (src_y << W_LOG) + src_x;

    mem_addr_d  = in_win ? ADDR_W'(addr_full) : mem_addr_q;
    mem_rd_en_d = in_win;

    // Frame controls only change at the raster origin so a frame renders consistently.
    at_origin = (x == 10'd0) && (y == 10'd0);
    mode_sh_d = at_origin ? mode       : mode_sh_q;
    thr_sh_d  = at_origin ? threshold  : thr_sh_q;
    brd_rgb_d = at_origin ? border_rgb : brd_rgb_q;

    ctl_d[0] = '{win:  in_win,
                 brd:  in_ring,
                 last: in_win && (xi == X_END - 1) && (yi == Y_END - 1),
                 hs:   hsync_in,
                 vs:   vsync_in};
    for (int i = 1; i < DEPTH; i++) begin
      ctl_d[i] = ctl_q[i-1];
    end
  end

  assign ctl_out = ctl_q[DEPTH-1];

  always_comb begin
    pix_rgb = 24'h0;
    case (mode_sh_q)
      2'b00:   pix_rgb = {3{ReadData}};
      2'b01:   pix_rgb = {3{~ReadData}};
      2'b10:   pix_rgb = (ReadData >= thr_sh_q) ? 24'hFFFFFF : 24'h000000;
      default: pix_rgb = {ReadData[7:5], ReadData[7:5], ReadData[7:6],
                          ReadData[4:2], ReadData[4:2], ReadData[4:3],
                          {4{ReadData[1:0]}}};
    endcase
    rgb_d        = ctl_out.win ? pix_rgb : (ctl_out.brd ? brd_rgb_q : 24'h0);
    hsync_d      = ctl_out.hs;
    vsync_d      = ctl_out.vs;
    frame_done_d = ctl_out.last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_q   <= '0;
      mem_rd_en_q  <= 1'b0;
      mode_sh_q    <= 2'b00;
      thr_sh_q     <= 8'h80;
      brd_rgb_q    <= 24'h0;
      rgb_q        <= 24'h0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      frame_done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ctl_q[i] <= CTL_IDLE;
      end
    end else begin
      mem_addr_q   <= mem_addr_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mode_sh_q    <= mode_sh_d;
      thr_sh_q     <= thr_sh_d;
      brd_rgb_q    <= brd_rgb_d;
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < DEPTH; i++) begin
        ctl_q[i] <= ctl_d[i];
      end
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_rd_en  = mem_rd_en_q;
  assign red        = rgb_q[23:16];
  assign green      = rgb_q[15:8];
  assign blue       = rgb_q[7:0];
  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_image_window_renderer.sv
// Scoreboard bench: two renderer configurations share one raster stimulus stream,
// expected responses come from a coordinate-level model and are checked by a monitor.
module tb_image_window_renderer;

  // Configuration A: defaults with a 2-pixel border.
  localparam int AW = 256, AH = 256, AL = 0, AT = 0, AS = 0, AML = 1, AAW = 16, AB = 2;
  // Configuration B: 2x scaling, deep memory latency.
  localparam int BW = 256, BH = 4, BL = 0, BT = 0, BS = 1, BML = 3, BAW = 10, BB = 3;
  localparam int LA = AML + 2;
  localparam int LB = BML + 2;

  logic        clk;
  logic        rst;
  logic [9:0]  x, y;
  logic        video_on, hsync_in, vsync_in;
  logic [1:0]  mode;
  logic [7:0]  threshold;
  logic [23:0] border_rgb;

  logic [AAW-1:0] mem_addr_a;
  logic           rd_en_a, hs_a, vs_a, fd_a;
  logic [7:0]     rdata_a, r_a, g_a, b_a;
  logic [BAW-1:0] mem_addr_b;
  logic           rd_en_b, hs_b, vs_b, fd_b;
  logic [7:0]     rdata_b, r_b, g_b, b_b;
  logic [7:0]     rdb_q [BML];

  logic [7:0] mem_a [0:65535];
  logic [7:0] mem_b [0:1023];

  image_window_renderer #(.IMG_W(AW), .IMG_H(AH), .LEFT(AL), .TOP(AT), .SCALE_SHIFT(AS),
                          .MEM_LATENCY(AML), .ADDR_W(AAW), .BORDER(AB)) dut_a (
    .clk(clk), .rst(rst), .x(x), .y(y), .video_on(video_on), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .mode(mode), .threshold(threshold), .border_rgb(border_rgb),
    .mem_addr(mem_addr_a), .mem_rd_en(rd_en_a), .ReadData(rdata_a),
    .red(r_a), .green(g_a), .blue(b_a), .hsync_out(hs_a), .vsync_out(vs_a), .frame_done(fd_a));

  image_window_renderer #(.IMG_W(BW), .IMG_H(BH), .LEFT(BL), .TOP(BT), .SCALE_SHIFT(BS),
                          .MEM_LATENCY(BML), .ADDR_W(BAW), .BORDER(BB)) dut_b (
    .clk(clk), .rst(rst), .x(x), .y(y), .video_on(video_on), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .mode(mode), .threshold(threshold), .border_rgb(border_rgb),
    .mem_addr(mem_addr_b), .mem_rd_en(rd_en_b), .ReadData(rdata_b),
    .red(r_b), .green(g_b), .blue(b_b), .hsync_out(hs_b), .vsync_out(vs_b), .frame_done(fd_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories with MEM_LATENCY cycles of read latency.
  always @(posedge clk) rdata_a <= mem_a[mem_addr_a];
  always @(posedge clk) begin
    rdb_q[0] <= mem_b[mem_addr_b];
    for (int i = 1; i < BML; i++) rdb_q[i] <= rdb_q[i-1];
  end
  assign rdata_b = rdb_q[BML-1];

  typedef struct {
    int   s;
    logic en;
    int   addr;
  } aexp_t;

  typedef struct {
    int          s;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        fd;
  } oexp_t;

  typedef struct {
    logic win;
    logic ring;
    logic last;
    int   addr;
  } geo_t;

  aexp_t qa_a[$], qa_b[$];
  oexp_t qo_a[$], qo_b[$];

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int last_rst_edge = -100;

  logic [1:0]  sh_mode;
  logic [7:0]  sh_thr;
  logic [23:0] sh_brgb;
  int          hold_a, hold_b;

  function automatic geo_t geo(int xx, int yy, logic vid, int w, int h, int l, int t,
                               int s, int b, int aw);
    geo_t g;
    int   ww, wh;
    ww     = w * (1 << s);
    wh     = h * (1 << s);
    g.win  = vid && xx >= l && xx < l + ww && yy >= t && yy < t + wh;
    g.ring = vid && !g.win && b > 0 && xx >= l - b && xx < l + ww + b &&
             yy >= t - b && yy < t + wh + b;
    g.last = g.win && xx == l + ww - 1 && yy == t + wh - 1;
    g.addr = 0;
    if (g.win) g.addr = (((yy - t) / (1 << s)) * w + (xx - l) / (1 << s)) % (1 << aw);
    return g;
  endfunction

  function automatic logic [23:0] render(logic [1:0] md, logic [7:0] th, logic [7:0] d);
    int r3, g3, b2;
    logic [7:0] rr, gg, bb;
    r3 = int'(d) / 32;
    g3 = (int'(d) / 4) % 8;
    b2 = int'(d) % 4;
    case (md)
      2'd0:    return {d, d, d};
      2'd1:    return {~d, ~d, ~d};
      2'd2:    return (d >= th) ? 24'hFFFFFF : 24'h000000;
      default: begin
        rr = 8'(r3 * 32 + r3 * 4 + r3 / 2);
        gg = 8'(g3 * 32 + g3 * 4 + g3 / 2);
        bb = 8'(b2 * 85);
        return {rr, gg, bb};
      end
    endcase
  endfunction

  task automatic check(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", nm, edge_cnt, got, exp);
    end
  endtask

  // Drive one raster sample and record what both renderers must produce for it.
  task automatic apply(bit r, int xx, int yy, logic vid, logic hs, logic vs,
                       logic [1:0] md, logic [7:0] th, logic [23:0] br);
    int    s;
    geo_t  g;
    aexp_t ae;
    oexp_t oe;
    @(negedge clk);
    rst = r; x = 10'(xx); y = 10'(yy); video_on = vid; hsync_in = hs; vsync_in = vs;
    mode = md; threshold = th; border_rgb = br;
    s = edge_cnt + 1;
    if (r) begin
      sh_mode = 2'd0; sh_thr = 8'h80; sh_brgb = 24'h0;
      hold_a = 0; hold_b = 0;
      last_rst_edge = s;
      ae.s = s; ae.en = 1'b0; ae.addr = 0;
      oe.s = s; oe.rgb = 24'h0; oe.hs = 1'b1; oe.vs = 1'b1; oe.fd = 1'b0;
      qa_a.push_back(ae); qa_b.push_back(ae);
      qo_a.push_back(oe); qo_b.push_back(oe);
    end else begin
      if (xx == 0 && yy == 0) begin
        sh_mode = md; sh_thr = th; sh_brgb = br;
      end
      g = geo(xx, yy, vid, AW, AH, AL, AT, AS, AB, AAW);
      if (g.win) hold_a = g.addr;
      ae.s = s; ae.en = g.win; ae.addr = hold_a;
      qa_a.push_back(ae);
      oe.s = s; oe.hs = hs; oe.vs = vs; oe.fd = g.last;
      oe.rgb = g.win ? render(sh_mode, sh_thr, mem_a[g.addr]) : (g.ring ? sh_brgb : 24'h0);
      qo_a.push_back(oe);

      g = geo(xx, yy, vid, BW, BH, BL, BT, BS, BB, BAW);
      if (g.win) hold_b = g.addr;
      ae.s = s; ae.en = g.win; ae.addr = hold_b;
      qa_b.push_back(ae);
      oe.s = s; oe.hs = hs; oe.vs = vs; oe.fd = g.last;
      oe.rgb = g.win ? render(sh_mode, sh_thr, mem_b[g.addr]) : (g.ring ? sh_brgb : 24'h0);
      qo_b.push_back(oe);
    end
  endtask

  task automatic px(int xx, int yy);
    apply(0, xx, yy, 1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom),
          24'($urandom));
  endtask

  // Blanking before the origin keeps in-flight pixels black across a control change.
  task automatic frame_start(logic [1:0] md, logic [7:0] th, logic [23:0] br);
    for (int i = 0; i < 6; i++)
      apply(0, 700, 700, 1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom),
            24'($urandom));
    apply(0, 0, 0, 1'b1, 1'b1, 1'b1, md, th, br);
  endtask

  function automatic int pick_x();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 1023));
      1:       return int'($urandom_range(250, 262));
      2:       return int'($urandom_range(505, 518));
      default: return int'($urandom_range(0, 8));
    endcase
  endfunction

  function automatic int pick_y();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 1023));
      1:       return int'($urandom_range(250, 262));
      2:       return int'($urandom_range(0, 12));
      default: return int'($urandom_range(0, 4));
    endcase
  endfunction

  // Monitor: every renderer presents a result each cycle; compare against the scoreboard.
  initial begin
    aexp_t ae;
    oexp_t oe;
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      while (qa_a.size() > 0 && qa_a[0].s <= edge_cnt) begin
        ae = qa_a.pop_front();
        check("A_rd_en", int'(rd_en_a), int'(ae.en));
        check("A_addr", int'(mem_addr_a), ae.addr);
      end
      while (qa_b.size() > 0 && qa_b[0].s <= edge_cnt) begin
        ae = qa_b.pop_front();
        check("B_rd_en", int'(rd_en_b), int'(ae.en));
        check("B_addr", int'(mem_addr_b), ae.addr);
      end
      while (qo_a.size() > 0 && qo_a[0].s + LA - 1 <= edge_cnt) begin
        oe = qo_a.pop_front();
        if (last_rst_edge >= oe.s) begin
          oe.rgb = 24'h0; oe.hs = 1'b1; oe.vs = 1'b1; oe.fd = 1'b0;
        end
        check("A_rgb", int'({r_a, g_a, b_a}), int'(oe.rgb));
        check("A_sync", int'({hs_a, vs_a}), int'({oe.hs, oe.vs}));
        check("A_frame_done", int'(fd_a), int'(oe.fd));
      end
      while (qo_b.size() > 0 && qo_b[0].s + LB - 1 <= edge_cnt) begin
        oe = qo_b.pop_front();
        if (last_rst_edge >= oe.s) begin
          oe.rgb = 24'h0; oe.hs = 1'b1; oe.vs = 1'b1; oe.fd = 1'b0;
        end
        check("B_rgb", int'({r_b, g_b, b_b}), int'(oe.rgb));
        check("B_sync", int'({hs_b, vs_b}), int'({oe.hs, oe.vs}));
        check("B_frame_done", int'(fd_b), int'(oe.fd));
      end
    end
  end

  initial begin
    int r;
    rst = 1'b1; x = '0; y = '0; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    mode = 2'd0; threshold = 8'h0; border_rgb = 24'h0;
    sh_mode = 2'd0; sh_thr = 8'h80; sh_brgb = 24'h0; hold_a = 0; hold_b = 0;
    for (int i = 0; i < 65536; i++) mem_a[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++) mem_b[i] = 8'($urandom);
    mem_a[517] = 8'h3C;
    mem_a[600] = 8'h40;
    mem_a[601] = 8'h3F;
    mem_a[602] = 8'hE3;

    for (int i = 0; i < 4; i++) apply(1, 0, 0, 1'b0, 1'b1, 1'b1, 2'd0, 8'h0, 24'h0);

    // Pass-through frame, scaled-address run along row 0, border probe.
    frame_start(2'd0, 8'h80, 24'h00FF00);
    for (int i = 1; i < 4; i++) px(i, 0);
    px(0, 2);
    px(5, 2);
    px(256, 0);
    px(257, 255);
    px(258, 0);
    px(100, 257);
    px(512, 3);
    px(514, 9);
    px(515, 9);

    // Threshold requested mid-frame: no effect until the next origin.
    apply(0, 88, 2, 1'b1, 1'b0, 1'b1, 2'd2, 8'h40, 24'h0);
    apply(0, 89, 2, 1'b1, 1'b1, 1'b0, 2'd2, 8'h40, 24'h0);
    frame_start(2'd2, 8'h40, 24'h123456);
    px(88, 2);
    px(89, 2);
    frame_start(2'd3, 8'h40, 24'h0000FF);
    px(90, 2);
    px(91, 2);

    // Last window pixel of each configuration, then one cut short by reset.
    px(AL + AW - 1, AT + AH - 1);
    px(10, 10);
    px(BL + (BW << BS) - 1, BT + (BH << BS) - 1);
    for (int i = 0; i < 6; i++) px(700, 700);
    px(AL + AW - 1, AT + AH - 1);
    apply(1, 0, 0, 1'b0, 1'b1, 1'b1, 2'd0, 8'h0, 24'h0);
    px(BL + (BW << BS) - 1, BT + (BH << BS) - 1);
    px(20, 1);
    apply(1, 0, 0, 1'b0, 1'b1, 1'b1, 2'd0, 8'h0, 24'h0);
    for (int i = 0; i < 6; i++) px(700, 700);

    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r == 0) apply(1, 0, 0, 1'b0, 1'b1, 1'b1, 2'd0, 8'h0, 24'h0);
      else if (r < 3) frame_start(2'($urandom), 8'($urandom), 24'($urandom));
      else begin
        int xx, yy;
        xx = pick_x();
        yy = pick_y();
        if (xx == 0 && yy == 0) xx = 1;
        apply(0, xx, yy, 1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
              2'($urandom), 8'($urandom), 24'($urandom));
      end
    end

    for (int i = 0; i < 8; i++) apply(0, 700, 700, 1'b0, 1'b1, 1'b1, 2'd0, 8'h0, 24'h0);
    repeat (LB + 3) @(posedge clk);
    #2;
    check("drain_A", qa_a.size() + qo_a.size(), 0);
    check("drain_B", qa_b.size() + qo_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
